// File: rtl/ahb_lite_mem_slave.sv
// ahb_lite_mem_slave: AHB-Lite slave fronting a byte-organised on-chip memory,
// with configurable wait states, two-cycle ERROR responses and write-to-read forwarding.
module ahb_lite_mem_slave #(
   parameter int                   DATAWIDTH   = 32,
   parameter int                   ADDRWIDTH   = 32,
   parameter int                   MEM_AW      = 8,
   parameter logic [ADDRWIDTH-1:0] BASE_ADDR   = '0,
   parameter int                   WAIT_STATES = 0
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 HSEL,
   input  logic [ADDRWIDTH-1:0] HADDR,
   input  logic                 HWRITE,
   input  logic [1:0]           HTRANS,
   input  logic [2:0]           HSIZE,
   input  logic [2:0]           HBURST,
   input  logic [DATAWIDTH-1:0] HWDATA,
   input  logic                 HREADY,
   output logic                 HREADYOUT,
   output logic                 HRESP,
   output logic [DATAWIDTH-1:0] HRDATA
);
   typedef enum logic [2:0] {IDLE_ST, WAIT_ST, DATA_ST, ERR1_ST, ERR2_ST} state_t;
   state_t               state, state_nx;
   logic [3:0]           cnt;
   logic [MEM_AW-1:0]    addr_q;
   logic                 write_q;
   logic [2:0]           size_q;
   logic [7:0]           mem [2**MEM_AW];
   logic                 can_accept, accept, legal, wr_en, fwd;
   logic [3:0]           lane_we;
   logic [DATAWIDTH-1:0] rd_word;
   logic                 unused;
   assign unused = ^{HBURST, HTRANS[0]};
   // Only states that present HREADYOUT=1 end a data phase, so only they can take a new address phase.
   assign can_accept = (state == IDLE_ST) || (state == DATA_ST) || (state == ERR2_ST);
   assign accept = can_accept && HSEL && HREADY && HTRANS[1];
   assign legal = (HADDR[ADDRWIDTH-1:MEM_AW] == BASE_ADDR[ADDRWIDTH-1:MEM_AW]) && (HSIZE <= 3'd2) &&
                  !(HSIZE == 3'd1 && HADDR[0]) && !(HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
   assign wr_en = HRESETn && (state == DATA_ST) && write_q;
   assign lane_we = (size_q == 3'd0) ? 4'b0001 << addr_q[1:0] :
                    (size_q == 3'd1) ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign fwd = wr_en && (addr_q[MEM_AW-1:2] == HADDR[MEM_AW-1:2]);
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state   <= IDLE_ST;
         cnt     <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
         HRDATA  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= (accept && legal) ? 4'(WAIT_STATES) : (state == WAIT_ST) ? cnt - 4'd1 : cnt;
         if (accept) begin
            addr_q  <= HADDR[MEM_AW-1:0];
            write_q <= HWRITE;
            size_q  <= HSIZE;
            HRDATA  <= (legal && !HWRITE) ? rd_word : '0;
         end
      end
   end
   always_comb begin
      state_nx = state;
      if (can_accept)
         state_nx = !accept ? IDLE_ST : !legal ? ERR1_ST : (WAIT_STATES == 0) ? DATA_ST : WAIT_ST;
      else if (state == WAIT_ST)
         state_nx = (cnt == 4'd1) ? DATA_ST : WAIT_ST;
      else
         state_nx = ERR2_ST;
   end
   always_comb begin
      HREADYOUT = !((state == WAIT_ST) || (state == ERR1_ST));
      HRESP     = (state == ERR1_ST) || (state == ERR2_ST);
   end
   always_ff @(posedge HCLK)
      for (int k = 0; k < 4; k++)
         if (wr_en && lane_we[k]) mem[{addr_q[MEM_AW-1:2], 2'(k)}] <= HWDATA[8*k +: 8];
   // A read accepted while a write to the same word completes sees the new bytes.
   always_comb
      for (int k = 0; k < 4; k++)
         rd_word[8*k +: 8] = (fwd && lane_we[k]) ? HWDATA[8*k +: 8] : mem[{HADDR[MEM_AW-1:2], 2'(k)}];
endmodule
